// File: rtl/spi_pkg.sv
// Shared state encoding and constants for the SPI slave control path.
package spi_pkg;

    typedef enum logic [2:0] {
        IDLE,
        GET_ADDR,
        DECODE,
        READ_LOAD,
        READ_SHIFT,
        WRITE_SHIFT,
        WRITE_COMMIT,
        DONE
    } spi_state_t;

    localparam logic RW_READ    = 1'b1;
    localparam int   DEF_ADDR_W = 7;
    localparam int   DEF_DATA_W = 8;

    function automatic int max_int(input int a, input int b);
        return (a > b) ? a : b;
    endfunction

endpackage

// File: rtl/spi_bit_counter.sv
// Counts sclk edges within one phase; flags when the next counted edge is the last one.
// Latency: count updates 1 clk after en; tc is combinational from the count and limit.
// Backpressure: none, clr has priority over en.
module spi_bit_counter #(
    parameter int W = 4
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         en,
    input  logic         clr,
    input  logic [W-1:0] limit,
    output logic [W-1:0] count,
    output logic         tc
);

    logic [W-1:0] count_q, count_d;

    always_comb begin
        count_d = count_q;
        if (clr) begin
            count_d = '0;
        end else if (en) begin
            count_d = count_q + W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    assign count = count_q;
    // High while limit-1 edges have been seen, so the caller qualifies it with the edge pulse.
    assign tc    = (count_q == (limit - W'(1)));

endmodule

// File: rtl/spi_slave_fsm_burst.sv
// Control FSM for the SPI memory peripheral: header, read/write words, optional burst.
// Latency: addr_we 1 clk after the last header edge, dm_we 1 clk after the last write edge.
// Backpressure: none; cs high ends the transaction on the next clk.
module spi_slave_fsm_burst
    import spi_pkg::*;
#(
    parameter int ADDR_W   = DEF_ADDR_W,
    parameter int DATA_W   = DEF_DATA_W,
    parameter bit BURST_EN = 1'b1,
    parameter int CNT_W    = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             sclk_edge,
    input  logic             cs,
    input  logic             rw,
    output logic             miso_buff,
    output logic             dm_we,
    output logic             addr_we,
    output logic             sr_we,
    output logic             addr_inc,
    output logic             abort,
    output logic             busy,
    output logic [CNT_W-1:0] words_done
);

    localparam int H  = ADDR_W + 1;
    localparam int CW = $clog2(max_int(H, DATA_W) + 1);

    spi_state_t       state_q, state_d;
    logic [CNT_W-1:0] words_done_q, words_done_d;
    logic [CW-1:0]    bit_cnt;
    logic [CW-1:0]    bit_limit;
    logic             bit_tc;
    logic             cnt_en;
    logic             cnt_clr;
    logic             word_inc;

    assign bit_limit = (state_q == GET_ADDR) ? CW'(H) : CW'(DATA_W);

    spi_bit_counter #(
        .W(CW)
    ) u_bit_counter (
        .clk   (clk),
        .reset (reset),
        .en    (cnt_en),
        .clr   (cnt_clr),
        .limit (bit_limit),
        .count (bit_cnt),
        .tc    (bit_tc)
    );

    always_comb begin
        state_d   = state_q;
        miso_buff = 1'b0;
        dm_we     = 1'b0;
        addr_we   = 1'b0;
        sr_we     = 1'b0;
        addr_inc  = 1'b0;
        abort     = 1'b0;
        cnt_en    = 1'b0;
        word_inc  = 1'b0;

        case (state_q)
            IDLE: begin
                if (!cs) state_d = GET_ADDR;
            end
            GET_ADDR: begin
                cnt_en = sclk_edge;
                if (sclk_edge && bit_tc) state_d = DECODE;
            end
            DECODE: begin
                addr_we = 1'b1;
                state_d = (rw == RW_READ) ? READ_LOAD : WRITE_SHIFT;
            end
            READ_LOAD: begin
                sr_we   = 1'b1;
                state_d = READ_SHIFT;
            end
            READ_SHIFT: begin
                miso_buff = 1'b1;
                cnt_en    = sclk_edge;
                if (sclk_edge && bit_tc) begin
                    word_inc = 1'b1;
                    if (BURST_EN) begin
                        addr_inc = 1'b1;
                        state_d  = READ_LOAD;
                    end else begin
                        state_d  = DONE;
                    end
                end
            end
            WRITE_SHIFT: begin
                cnt_en = sclk_edge;
                if (sclk_edge && bit_tc) state_d = WRITE_COMMIT;
            end
            WRITE_COMMIT: begin
                // The memory write uses the address register before this cycle's increment.
                dm_we    = 1'b1;
                word_inc = 1'b1;
                if (BURST_EN) begin
                    addr_inc = 1'b1;
                    state_d  = WRITE_SHIFT;
                end else begin
                    state_d  = DONE;
                end
            end
            DONE: begin
                state_d = DONE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        if (cs && (state_q != IDLE)) begin
            abort    = (state_q inside {GET_ADDR, READ_SHIFT, WRITE_SHIFT}) && (bit_cnt != '0);
            state_d  = IDLE;
            dm_we    = 1'b0;
            sr_we    = 1'b0;
            addr_inc = 1'b0;
            word_inc = 1'b0;
            cnt_en   = 1'b0;
        end

        // Reset must not leak a strobe, in particular a memory write from WRITE_COMMIT.
        if (reset) begin
            state_d   = IDLE;
            miso_buff = 1'b0;
            dm_we     = 1'b0;
            addr_we   = 1'b0;
            sr_we     = 1'b0;
            addr_inc  = 1'b0;
            abort     = 1'b0;
            word_inc  = 1'b0;
            cnt_en    = 1'b0;
        end

        cnt_clr = (state_d != state_q);

        words_done_d = words_done_q;
        if (state_d == IDLE) begin
            words_done_d = '0;
        end else if (word_inc && (words_done_q != {CNT_W{1'b1}})) begin
            words_done_d = words_done_q + CNT_W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q      <= IDLE;
            words_done_q <= '0;
        end else begin
            state_q      <= state_d;
            words_done_q <= words_done_d;
        end
    end

    assign busy       = (state_q != IDLE);
    assign words_done = words_done_q;

endmodule

// File: tb/tb_spi_slave_fsm_burst.sv
// Bench for spi_slave_fsm_burst: burst (CNT_W=2) and single-word instances share stimulus.
module tb_spi_slave_fsm_burst;

    localparam int H  = 8;
    localparam int DW = 8;

    localparam int GAP_NONE = 0, GAP_DEC = 1, GAP_LOAD = 2, GAP_COMMIT = 3;
    localparam int LST_HDR = 1, LST_DATA = 2;

    logic clk = 1'b0;
    logic reset, sclk_edge, cs, rw;

    logic miso_b, dm_b, aw_b, sr_b, inc_b, ab_b, busy_b;
    logic miso_s, dm_s, aw_s, sr_s, inc_s, ab_s, busy_s;
    logic [1:0] wd_b;
    logic [7:0] wd_s;

    always #5 clk = ~clk;

    spi_slave_fsm_burst #(.ADDR_W(7), .DATA_W(8), .BURST_EN(1'b1), .CNT_W(2)) dut_b (
        .clk(clk), .reset(reset), .sclk_edge(sclk_edge), .cs(cs), .rw(rw),
        .miso_buff(miso_b), .dm_we(dm_b), .addr_we(aw_b), .sr_we(sr_b),
        .addr_inc(inc_b), .abort(ab_b), .busy(busy_b), .words_done(wd_b));

    spi_slave_fsm_burst #(.ADDR_W(7), .DATA_W(8), .BURST_EN(1'b0), .CNT_W(8)) dut_s (
        .clk(clk), .reset(reset), .sclk_edge(sclk_edge), .cs(cs), .rw(rw),
        .miso_buff(miso_s), .dm_we(dm_s), .addr_we(aw_s), .sr_we(sr_s),
        .addr_inc(inc_s), .abort(ab_s), .busy(busy_s), .words_done(wd_s));

    // Bit order: {miso_buff, dm_we, addr_we, sr_we, addr_inc, abort, busy}
    logic [6:0] out_b, out_s;
    assign out_b = {miso_b, dm_b, aw_b, sr_b, inc_b, ab_b, busy_b};
    assign out_s = {miso_s, dm_s, aw_s, sr_s, inc_s, ab_s, busy_s};

    int n_checks = 0;
    int n_fail   = 0;

    // Reference model: transaction progress as counters plus one pending single-clk action.
    int m_busy[2], m_listen[2], m_cnt[2], m_rd[2], m_done[2], m_words[2], m_gap[2];
    logic [6:0] smp_out[2];
    int         smp_wd[2];
    int         pc[2][8];

    typedef struct {
        int addr_we; int sr_we; int dm_we; int addr_inc; int abort; int words;
    } exp_t;
    typedef struct {
        bit rd; int hdr; int data; exp_t b; exp_t s;
    } scen_t;
    scen_t scen[8];

    task automatic chk(input string name, input int act, input int req);
        n_checks++;
        if (act != req) begin
            n_fail++;
            $display("FAIL %s: got %0d, required %0d", name, act, req);
        end
    endtask

    task automatic model_clear(input int d);
        m_busy[d] = 0; m_listen[d] = 0; m_cnt[d] = 0; m_rd[d] = 0;
        m_done[d] = 0; m_words[d] = 0; m_gap[d] = GAP_NONE;
    endtask

    task automatic model_step(input int d, input bit burst, input int wmax,
                              input logic c, input logic e, input logic r, input logic rs,
                              output logic [6:0] exp_o, output int exp_w);
        bit lst;
        exp_o = '0;
        exp_w = m_words[d];
        exp_o[0] = (m_busy[d] != 0);
        if (rs) begin
            model_clear(d);
            return;
        end
        if (m_busy[d] == 0) begin
            if (!c) begin
                m_busy[d] = 1; m_listen[d] = LST_HDR; m_cnt[d] = 0;
            end
            return;
        end
        lst = (m_gap[d] == GAP_NONE) && (m_done[d] == 0);
        exp_o[6] = lst && (m_listen[d] == LST_DATA) && (m_rd[d] != 0);
        if (m_gap[d] == GAP_DEC) exp_o[4] = 1'b1;
        if (c) begin
            exp_o[1] = lst && (m_cnt[d] > 0);
            model_clear(d);
            return;
        end
        case (m_gap[d])
            GAP_DEC: begin
                m_rd[d] = int'(r); m_listen[d] = LST_DATA; m_cnt[d] = 0;
                m_gap[d] = r ? GAP_LOAD : GAP_NONE;
            end
            GAP_LOAD: begin
                exp_o[3] = 1'b1; m_gap[d] = GAP_NONE;
            end
            GAP_COMMIT: begin
                exp_o[5] = 1'b1; exp_o[2] = burst;
                if (m_words[d] < wmax) m_words[d]++;
                m_gap[d] = GAP_NONE;
                if (!burst) m_done[d] = 1;
            end
            default: begin
                if (lst && e) begin
                    m_cnt[d]++;
                    if (m_listen[d] == LST_HDR && m_cnt[d] == H) begin
                        m_gap[d] = GAP_DEC; m_cnt[d] = 0;
                    end else if (m_listen[d] == LST_DATA && m_cnt[d] == DW) begin
                        m_cnt[d] = 0;
                        if (m_rd[d] != 0) begin
                            if (m_words[d] < wmax) m_words[d]++;
                            if (burst) begin
                                exp_o[2] = 1'b1; m_gap[d] = GAP_LOAD;
                            end else begin
                                m_done[d] = 1;
                            end
                        end else begin
                            m_gap[d] = GAP_COMMIT;
                        end
                    end
                end
            end
        endcase
    endtask

    task automatic cyc_check(input string name, input logic [6:0] act, input int act_w,
                             input logic [6:0] req, input int req_w);
        n_checks++;
        if (act !== req || act_w != req_w) begin
            n_fail++;
            $display("FAIL cycle_%s t=%0t: out=%b words=%0d, required out=%b words=%0d",
                     name, $time, act, act_w, req, req_w);
        end
    endtask

    task automatic tick(input logic c, input logic e, input logic r, input logic rs);
        logic [6:0] e0, e1;
        int w0, w1;
        cs = c; sclk_edge = e; rw = r; reset = rs;
        @(negedge clk);
        model_step(0, 1'b1, 3, c, e, r, rs, e0, w0);
        model_step(1, 1'b0, 255, c, e, r, rs, e1, w1);
        cyc_check("burst", out_b, int'(wd_b), e0, w0);
        cyc_check("single", out_s, int'(wd_s), e1, w1);
        smp_out[0] = out_b; smp_out[1] = out_s;
        smp_wd[0]  = int'(wd_b); smp_wd[1] = int'(wd_s);
        for (int k = 1; k <= 5; k++) begin
            pc[0][k] += int'(out_b[k]);
            pc[1][k] += int'(out_s[k]);
        end
        @(posedge clk);
        #1;
    endtask

    // One sclk edge followed by 2..4 quiet clocks keeps edges at least 3 clk apart.
    task automatic edge_gap(input logic r);
        tick(1'b0, 1'b1, r, 1'b0);
        repeat ($urandom_range(2, 4)) tick(1'b0, 1'b0, r, 1'b0);
    endtask

    task automatic end_txn();
        tick(1'b1, 1'b0, 1'b0, 1'b0);
        tick(1'b1, 1'b0, 1'b0, 1'b0);
    endtask

    task automatic check_exp(input string tag, input int d, input exp_t x);
        chk({tag, "_addr_we"},  pc[d][4], x.addr_we);
        chk({tag, "_sr_we"},    pc[d][3], x.sr_we);
        chk({tag, "_dm_we"},    pc[d][5], x.dm_we);
        chk({tag, "_addr_inc"}, pc[d][2], x.addr_inc);
        chk({tag, "_abort"},    pc[d][1], x.abort);
    endtask

    task automatic run_scen(input int idx);
        scen_t s;
        s = scen[idx];
        for (int d = 0; d < 2; d++)
            for (int k = 0; k < 8; k++) pc[d][k] = 0;
        tick(1'b0, 1'b0, s.rd, 1'b0);
        for (int i = 0; i < s.hdr; i++) edge_gap(s.rd);
        for (int i = 0; i < s.data; i++) edge_gap(s.rd);
        repeat (4) tick(1'b0, 1'b0, s.rd, 1'b0);
        chk($sformatf("scen%0d_b_words", idx), smp_wd[0], s.b.words);
        chk($sformatf("scen%0d_s_words", idx), smp_wd[1], s.s.words);
        end_txn();
        check_exp($sformatf("scen%0d_b", idx), 0, s.b);
        check_exp($sformatf("scen%0d_s", idx), 1, s.s);
    endtask

    initial begin
        #5_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        model_clear(0);
        model_clear(1);
        reset = 1'b1; cs = 1'b1; sclk_edge = 1'b0; rw = 1'b0;
        @(posedge clk);
        #1;
        tick(1'b1, 1'b0, 1'b0, 1'b1);
        tick(1'b1, 1'b0, 1'b0, 1'b0);
        chk("reset_out_burst", int'(smp_out[0]), 0);
        chk("reset_out_single", int'(smp_out[1]), 0);
        chk("reset_words_single", smp_wd[1], 0);

        // Fields: rd, header edges, data edges, burst {addr_we,sr_we,dm_we,addr_inc,abort,words}, single {...}
        scen[0] = '{1'b0, 8,  8, '{1, 0, 1, 1, 0, 1}, '{1, 0, 1, 0, 0, 1}};
        scen[1] = '{1'b1, 8,  8, '{1, 2, 0, 1, 0, 1}, '{1, 1, 0, 0, 0, 1}};
        scen[2] = '{1'b0, 8, 24, '{1, 0, 3, 3, 0, 3}, '{1, 0, 1, 0, 0, 1}};
        scen[3] = '{1'b1, 8, 16, '{1, 3, 0, 2, 0, 2}, '{1, 1, 0, 0, 0, 1}};
        scen[4] = '{1'b0, 8, 13, '{1, 0, 1, 1, 1, 1}, '{1, 0, 1, 0, 0, 1}};
        scen[5] = '{1'b0, 8,  5, '{1, 0, 0, 0, 1, 0}, '{1, 0, 0, 0, 1, 0}};
        scen[6] = '{1'b0, 8, 40, '{1, 0, 5, 5, 0, 3}, '{1, 0, 1, 0, 0, 1}};
        scen[7] = '{1'b0, 3,  0, '{0, 0, 0, 0, 1, 0}, '{0, 0, 0, 0, 1, 0}};
        for (int i = 0; i < 8; i++) run_scen(i);

        // Write latency: addr_we one clk after header edge 8, dm_we one clk after data edge 8.
        tick(1'b0, 1'b0, 1'b0, 1'b0);
        for (int i = 0; i < H - 1; i++) edge_gap(1'b0);
        tick(1'b0, 1'b1, 1'b0, 1'b0);
        tick(1'b0, 1'b0, 1'b0, 1'b0);
        chk("wr_addr_we_latency", int'(smp_out[1][4]), 1);
        for (int i = 0; i < DW - 1; i++) edge_gap(1'b0);
        tick(1'b0, 1'b1, 1'b0, 1'b0);
        tick(1'b0, 1'b0, 1'b0, 1'b0);
        chk("wr_dm_we_latency_single", int'(smp_out[1][5]), 1);
        chk("wr_dm_we_latency_burst", int'(smp_out[0][5]), 1);
        chk("wr_addr_inc_with_dm_we", int'(smp_out[0][2]), 1);
        end_txn();

        // Read: addr_we, then sr_we with miso off, then miso on.
        tick(1'b0, 1'b0, 1'b1, 1'b0);
        for (int i = 0; i < H - 1; i++) edge_gap(1'b1);
        tick(1'b0, 1'b1, 1'b1, 1'b0);
        tick(1'b0, 1'b0, 1'b1, 1'b0);
        chk("rd_addr_we", int'(smp_out[1][4]), 1);
        tick(1'b0, 1'b0, 1'b1, 1'b0);
        chk("rd_sr_we", int'(smp_out[1][3]), 1);
        chk("rd_no_miso_with_sr_we", int'(smp_out[1][6]), 0);
        tick(1'b0, 1'b0, 1'b1, 1'b0);
        chk("rd_miso_on", int'(smp_out[1][6]), 1);
        end_txn();

        // Reset during the header phase.
        tick(1'b0, 1'b0, 1'b0, 1'b0);
        for (int i = 0; i < 3; i++) edge_gap(1'b0);
        tick(1'b0, 1'b0, 1'b0, 1'b1);
        tick(1'b1, 1'b0, 1'b0, 1'b0);
        chk("rst_hdr_busy_burst", int'(smp_out[0]), 0);
        chk("rst_hdr_busy_single", int'(smp_out[1]), 0);

        // Reset in the commit cycle must swallow the memory write.
        tick(1'b0, 1'b0, 1'b0, 1'b0);
        for (int i = 0; i < H + DW - 1; i++) edge_gap(1'b0);
        tick(1'b0, 1'b1, 1'b0, 1'b0);
        tick(1'b0, 1'b0, 1'b0, 1'b1);
        chk("rst_commit_no_dm_we", int'(smp_out[1][5]), 0);
        tick(1'b1, 1'b0, 1'b0, 1'b0);
        chk("rst_commit_words", smp_wd[1], 0);
        tick(1'b1, 1'b0, 1'b0, 1'b0);

        // Randomised transactions, checked cycle by cycle against the model.
        for (int t = 0; t < 60; t++) begin
            int nh;
            int nd;
            nh = ($urandom_range(0, 7) == 0) ? $urandom_range(0, H) : H;
            nd = $urandom_range(0, 40);
            tick(1'b0, 1'b0, 1'($urandom_range(0, 1)), 1'b0);
            for (int i = 0; i < nh + nd; i++) begin
                tick(1'b0, 1'b1, 1'($urandom_range(0, 1)), 1'b0);
                repeat ($urandom_range(2, 4))
                    tick(1'b0, 1'b0, 1'($urandom_range(0, 1)),
                         1'($urandom_range(0, 149) == 0));
            end
            repeat ($urandom_range(0, 4)) tick(1'b0, 1'b0, 1'($urandom_range(0, 1)), 1'b0);
            repeat ($urandom_range(1, 2)) tick(1'b1, 1'b0, 1'b0, 1'b0);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
